load_store_sequencer: RTL and testbench



---
 rtl/load_store_sequencer_pkg.sv | 45 ++++
 rtl/load_store_sequencer_store_merge.sv | 38 +++
 rtl/load_store_sequencer.sv | 133 +++++++++++++
 tb/tb_load_store_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/load_store_sequencer_pkg.sv
// load_store_sequencer_pkg: shared definitions for the load/store sequencer.
//   - OP_* : opcode encodings presented on i_op by the main control unit.
//   - state_e : sequencer FSM states.
//   - merge_e : selects word / halfword / byte handling for merge and extract.
//   - helper functions classifying an opcode.
package load_store_sequencer_pkg;

  localparam logic [2:0] OP_LW = 3'd0;
  localparam logic [2:0] OP_LH = 3'd1;
  localparam logic [2:0] OP_LB = 3'd2;
  localparam logic [2:0] OP_SW = 3'd3;
  localparam logic [2:0] OP_SH = 3'd4;
  localparam logic [2:0] OP_SB = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWait,
    StWrite,
    StFinish
  } state_e;

  typedef enum logic [1:0] {
    MRG_WORD,
    MRG_HALF,
    MRG_BYTE
  } merge_e;

  function automatic merge_e op_to_merge(input logic [2:0] op);
    case (op)
      OP_LH, OP_SH: return MRG_HALF;
      OP_LB, OP_SB: return MRG_BYTE;
      default:      return MRG_WORD;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LB);
  endfunction

  function automatic logic op_is_illegal(input logic [2:0] op);
    return op > OP_SB;
  endfunction

endpackage

// File: rtl/load_store_sequencer_store_merge.sv
// load_store_sequencer_store_merge: combinational data path for sub-word accesses.
//   i_mdr    : memory data register (old memory word for read-modify-write)
//   i_b      : store source register
//   i_rdata  : word being captured from memory, source for the load result
//   i_sel    : word / half / byte select
//   o_wdata  : word to write back (upper bits from i_mdr, low bits from i_b)
//   o_load   : zero-extended load result taken from the low bits of i_rdata
module load_store_sequencer_store_merge
  import load_store_sequencer_pkg::*;
(
  input  logic [31:0] i_mdr,
  input  logic [31:0] i_b,
  input  logic [31:0] i_rdata,
  input  merge_e      i_sel,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load
);

  always_comb begin
    o_wdata = i_b;
    o_load  = i_rdata;
    case (i_sel)
      MRG_HALF: begin
        o_wdata = {i_mdr[31:16], i_b[15:0]};
        o_load  = {16'b0, i_rdata[15:0]};
      end
      MRG_BYTE: begin
        o_wdata = {i_mdr[31:8], i_b[7:0]};
        o_load  = {24'b0, i_rdata[7:0]};
      end
      default: begin
        o_wdata = i_b;
        o_load  = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_sequencer.sv
// load_store_sequencer: multicycle controller sequencing LW/LH/LB/SW/SH/SB.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_start, i_op         : request from the control unit (sampled only when idle)
//   i_addr, i_b_data      : effective address and store source
//   o_mem_addr, o_mem_wr  : memory address and write strobe
//   o_mem_wdata           : memory write data (zero unless writing)
//   i_mem_rdata           : memory read data, valid MEM_LAT cycles after the read
//   o_load_data           : registered zero-extended load result
//   o_reg_write           : pulse telling the register file to take o_load_data
//   o_busy, o_done, o_err : status; o_err accompanies o_done for illegal ops
module load_store_sequencer
  import load_store_sequencer_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [2:0]        i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_b_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  output logic [31:0]       o_load_data,
  output logic              o_reg_write,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam logic [2:0] LastCnt = 3'(MEM_LAT - 1);

  state_e            r_state, w_state_d;
  logic [2:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_b;
  logic [31:0]       r_mdr;
  logic [31:0]       r_load_data;
  logic [2:0]        r_cnt;
  logic              r_err;

  merge_e      w_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_load;
  logic        w_last_wait;

  assign w_sel       = op_to_merge(r_op);
  assign w_last_wait = (r_state == StWait) && (r_cnt == LastCnt);

  load_store_sequencer_store_merge u_store_merge (
    .i_mdr   (r_mdr),
    .i_b     (r_b),
    .i_rdata (i_mem_rdata),
    .i_sel   (w_sel),
    .o_wdata (w_wdata),
    .o_load  (w_load)
  );

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          if (op_is_illegal(i_op)) begin
            w_state_d = StFinish;
          end else if (i_op == OP_SW) begin
            w_state_d = StWrite;
          end else begin
            w_state_d = StRead;
          end
        end
      end
      StRead:   w_state_d = StWait;
      StWait: begin
        if (r_cnt == LastCnt) begin
          w_state_d = op_is_load(r_op) ? StFinish : StWrite;
        end
      end
      StWrite:  w_state_d = StFinish;
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_mem_addr  = r_addr;
    o_busy      = (r_state != StIdle);
    o_mem_wr    = (r_state == StWrite);
    o_mem_wdata = (r_state == StWrite) ? w_wdata : 32'b0;
    o_done      = (r_state == StFinish);
    o_err       = (r_state == StFinish) && r_err;
    o_reg_write = (r_state == StFinish) && op_is_load(r_op);
    o_load_data = r_load_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_op        <= 3'b0;
      r_addr      <= '0;
      r_b         <= 32'b0;
      r_mdr       <= 32'b0;
      r_load_data <= 32'b0;
      r_cnt       <= 3'b0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if ((r_state == StIdle) && i_start) begin
        r_op   <= i_op;
        r_addr <= i_addr;
        r_b    <= i_b_data;
        r_err  <= op_is_illegal(i_op);
      end
      if (r_state == StRead) begin
        r_cnt <= 3'b0;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt + 3'd1;
      end
      // The load result is registered at the same edge that fills the MDR so it
      // is already valid in the FINISH cycle.
      if (w_last_wait) begin
        r_mdr <= i_mem_rdata;
        if (op_is_load(r_op)) begin
          r_load_data <= w_load;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_sequencer.sv
// tb_load_store_sequencer: self-checking bench with two sequencers (MEM_LAT 1 and 3).
module tb_load_store_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_s [2];
  logic [2:0]  op_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] b_s     [2];
  logic [31:0] rdata_s [2];
  logic [31:0] maddr_s [2];
  logic [31:0] wdata_s [2];
  logic [31:0] ld_s    [2];
  logic        wr_s    [2];
  logic        rw_s    [2];
  logic        busy_s  [2];
  logic        done_s  [2];
  logic        err_s   [2];

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_ld [2];

  load_store_sequencer #(.MEM_LAT(1), .ADDR_W(32)) u_lat1 (
    .i_clk(clk), .i_reset(rst), .i_start(start_s[0]), .i_op(op_s[0]), .i_addr(addr_s[0]),
    .i_b_data(b_s[0]), .o_mem_addr(maddr_s[0]), .o_mem_wr(wr_s[0]), .o_mem_wdata(wdata_s[0]),
    .i_mem_rdata(rdata_s[0]), .o_load_data(ld_s[0]), .o_reg_write(rw_s[0]),
    .o_busy(busy_s[0]), .o_done(done_s[0]), .o_err(err_s[0])
  );

  load_store_sequencer #(.MEM_LAT(3), .ADDR_W(32)) u_lat3 (
    .i_clk(clk), .i_reset(rst), .i_start(start_s[1]), .i_op(op_s[1]), .i_addr(addr_s[1]),
    .i_b_data(b_s[1]), .o_mem_addr(maddr_s[1]), .o_mem_wr(wr_s[1]), .o_mem_wdata(wdata_s[1]),
    .i_mem_rdata(rdata_s[1]), .o_load_data(ld_s[1]), .o_reg_write(rw_s[1]),
    .o_busy(busy_s[1]), .o_done(done_s[1]), .o_err(err_s[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain arithmetic from the operation rules.
  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int exp_cycles(input logic [2:0] op, input int lat);
    if (op <= 3'd2) return 2 + lat;
    if (op == 3'd3) return 2;
    if (op <= 3'd5) return 3 + lat;
    return 1;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] b,
                                            input logic [31:0] word);
    if (op == 3'd4) return (word & 32'hFFFF_0000) | (b & 32'h0000_FFFF);
    if (op == 3'd5) return (word & 32'hFFFF_FF00) | (b & 32'h0000_00FF);
    return b;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] word);
    if (op == 3'd1) return word % 32'h1_0000;
    if (op == 3'd2) return word % 32'h100;
    return word;
  endfunction

  // Runs one operation on sequencer k. Memory returns 'word' only in the last
  // cycle of the latency window and only for the requested address.
  task automatic run_op(input int k, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] b, input logic [31:0] word, input bit hold,
                        input logic [2:0] nop, input logic [31:0] naddr,
                        input logic [31:0] nb, input bit noise);
    int          lat, ncyc, done_cyc, wr_cnt, wr_cyc, rw_cnt, wz_bad;
    logic [31:0] wd_seen, wa_seen, ld_seen;
    logic        err_seen, rw_seen;
    bit          is_ld, is_st, is_ill;
    lat    = lat_of(k);
    ncyc   = exp_cycles(op, lat);
    is_ld  = (op <= 3'd2);
    is_st  = (op >= 3'd3) && (op <= 3'd5);
    is_ill = (op > 3'd5);
    done_cyc = -1; wr_cnt = 0; wr_cyc = -1; rw_cnt = 0; wz_bad = 0;
    wd_seen = 'x; wa_seen = 'x; ld_seen = 'x; err_seen = 1'bx; rw_seen = 1'bx;
    @(negedge clk);
    start_s[k] = 1'b1; op_s[k] = op; addr_s[k] = addr; b_s[k] = b;
    rdata_s[k] = 32'hBAD0_BAD0;
    chk("idle_before_start", 32'(busy_s[k]), 32'd0);
    @(posedge clk);
    #1;
    if (hold) begin
      op_s[k] = nop; addr_s[k] = naddr; b_s[k] = nb;
    end else begin
      start_s[k] = 1'b0;
    end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      rdata_s[k] = ((n == 1 + lat) && (maddr_s[k] == addr)) ? word : 32'hBAD0_BAD0;
      if (wr_s[k]) begin
        wr_cnt++; wr_cyc = n; wd_seen = wdata_s[k]; wa_seen = maddr_s[k];
      end else if (wdata_s[k] !== 32'd0) begin
        wz_bad++;
      end
      if (rw_s[k]) rw_cnt++;
      if (done_s[k] && done_cyc < 0) begin
        done_cyc = n; err_seen = err_s[k]; rw_seen = rw_s[k]; ld_seen = ld_s[k];
      end
      // Requests while busy must be ignored; keep them off once the op should end.
      if (!hold) begin
        if (noise && n < ncyc) begin
          start_s[k] = 1'($urandom); op_s[k] = 3'($urandom);
          addr_s[k] = $urandom; b_s[k] = $urandom;
        end else begin
          start_s[k] = 1'b0;
        end
      end
      if (n >= ncyc && done_cyc >= 0) break;
    end
    chk("done_cycle", 32'(done_cyc), 32'(ncyc));
    chk("err_at_done", 32'(err_seen), 32'(is_ill));
    chk("reg_write_at_done", 32'(rw_seen), 32'(is_ld));
    chk("reg_write_count", 32'(rw_cnt), is_ld ? 32'd1 : 32'd0);
    chk("mem_wr_count", 32'(wr_cnt), is_st ? 32'd1 : 32'd0);
    if (is_st) begin
      chk("write_cycle", 32'(wr_cyc), 32'(ncyc - 1));
      chk("write_data", wd_seen, exp_wdata(op, b, word));
      chk("write_addr", wa_seen, addr);
    end
    if (is_ld) last_ld[k] = exp_load(op, word);
    chk("load_data", ld_seen, last_ld[k]);
    chk("wdata_zero_when_idle", 32'(wz_bad), 32'd0);
  endtask

  initial begin
    int rst_bad;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; op_s[k] = 3'd0; addr_s[k] = 32'd0; b_s[k] = 32'd0;
      rdata_s[k] = 32'hBAD0_BAD0; last_ld[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_busy", 32'(busy_s[k]), 32'd0);
      chk("reset_done", 32'(done_s[k]), 32'd0);
      chk("reset_err", 32'(err_s[k]), 32'd0);
      chk("reset_mem_wr", 32'(wr_s[k]), 32'd0);
      chk("reset_reg_write", 32'(rw_s[k]), 32'd0);
      chk("reset_load_data", ld_s[k], 32'd0);
      chk("reset_wdata", wdata_s[k], 32'd0);
      chk("reset_mem_addr", maddr_s[k], 32'd0);
    end
    rst = 1'b0;

    // Directed operations.
    run_op(0, 3'd0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    run_op(0, 3'd1, 32'h44, 32'h0, 32'h1234_ABCD, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    run_op(0, 3'd2, 32'h44, 32'h0, 32'h1234_ABCD, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    run_op(0, 3'd4, 32'h80, 32'hFFFF_5678, 32'hAAAA_BBBB, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    run_op(0, 3'd5, 32'h80, 32'h0000_0011, 32'hAAAA_BBBB, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    // SW then LW with start held high the whole time.
    run_op(1, 3'd3, 32'h100, 32'hCAFE_F00D, 32'h0, 1'b1, 3'd0, 32'h104, 32'h0, 1'b0);
    run_op(1, 3'd0, 32'h104, 32'h0, 32'h5555_AAAA, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    run_op(0, 3'd7, 32'hC0, 32'h1, 32'h2, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    run_op(1, 3'd6, 32'hC4, 32'h1, 32'h2, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

    // Reset while an SH sits in its wait window.
    @(negedge clk);
    start_s[1] = 1'b1; op_s[1] = 3'd4; addr_s[1] = 32'h200; b_s[1] = 32'h1234_5678;
    @(posedge clk);
    #1 start_s[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_busy", 32'(busy_s[1]), 32'd0);
    chk("reset_mid_mem_wr", 32'(wr_s[1]), 32'd0);
    chk("reset_mid_done", 32'(done_s[1]), 32'd0);
    chk("reset_mid_load_data", ld_s[1], 32'd0);
    last_ld[0] = 32'd0; last_ld[1] = 32'd0;
    rst = 1'b0;
    rst_bad = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done_s[1] || wr_s[1] || busy_s[1]) rst_bad++;
    end
    chk("reset_mid_quiet", 32'(rst_bad), 32'd0);
    run_op(1, 3'd0, 32'h204, 32'h0, 32'h0BAD_F00D, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

    // Randomized operations on both latencies.
    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(1, 0)), 3'($urandom_range(7, 0)), $urandom, $urandom,
             $urandom, 1'b0, 3'd0, 32'd0, 32'd0, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
